// File: rtl/voice_envelope_adsr.sv
// voice_envelope_adsr: one time-multiplexed ADSR engine serving every voice.
// Define ENV_EXP_RELEASE_EN for an exponential release tail (shift in release_rate[3:0]).
module voice_envelope_adsr #(
    parameter int NUM_VOICES = 8,
    parameter int VOL_WIDTH  = 32,
    parameter int TICK_DIV   = 24000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_VOICES-1:0] gate,
    input  logic [15:0]           attack_rate,
    input  logic [15:0]           decay_rate,
    input  logic [15:0]           sustain_level,
    input  logic [15:0]           release_rate,
    output logic [VOL_WIDTH-1:0]  voice_volumes [NUM_VOICES],
    output logic [NUM_VOICES-1:0] voice_active,
    output logic                  busy,
    output logic                  tick
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int IW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX   = IW'(NUM_VOICES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ATTACK,
        S_DECAY,
        S_SUSTAIN,
        S_RELEASE
    } state_t;

    logic [PW-1:0]         r_presc;
    logic                  r_busy;
    logic [IW-1:0]         r_idx;
    logic [NUM_VOICES-1:0] r_gate_d;
    logic                  r_hist_vld;
    logic [NUM_VOICES-1:0] r_pend_on;
    logic [NUM_VOICES-1:0] r_pend_off;
    state_t                r_state [NUM_VOICES];
    logic [15:0]           r_level [NUM_VOICES];

    logic [NUM_VOICES-1:0] w_rise;
    logic [NUM_VOICES-1:0] w_fall;
    logic [NUM_VOICES-1:0] w_svc;
    state_t                w_cur_st;
    state_t                w_eff_st;
    state_t                w_nxt_st;
    logic [15:0]           w_cur_lv;
    logic [15:0]           w_nxt_lv;
    logic [16:0]           w_add;
    logic [16:0]           w_dsub;
    logic [16:0]           w_rdec;
    logic [16:0]           w_rsub;
    logic                  w_rel_hold;

    assign tick = (r_presc == PRESC_MAX);
    assign busy = r_busy;

    // Drive outputs straight from the per-voice registers.
    always_comb begin
        for (int i = 0; i < NUM_VOICES; i++) begin
            voice_volumes[i] = VOL_WIDTH'(r_level[i]);
            voice_active[i]  = (r_state[i] != S_IDLE);
        end
    end

    // Gate edges (masked on the first clock out of reset) and the serviced-voice mask.
    always_comb begin
        w_rise = gate & ~r_gate_d & {NUM_VOICES{r_hist_vld}};
        w_fall = ~gate & r_gate_d & {NUM_VOICES{r_hist_vld}};
        w_svc  = '0;
        if (r_busy) begin
            w_svc[r_idx] = 1'b1;
        end
    end

    // Prescaler and sweep walker: tick starts a sweep covering voices 0..N-1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_presc <= '0;
            r_busy  <= 1'b0;
            r_idx   <= '0;
        end else begin
            r_presc <= tick ? '0 : r_presc + PW'(1);
            if (tick) begin
                r_busy <= 1'b1;
                r_idx  <= '0;
            end else if (r_busy) begin
                if (r_idx == IDX_MAX) begin
                    r_busy <= 1'b0;
                end else begin
                    r_idx <= r_idx + IW'(1);
                end
            end
        end
    end

    // Edge capture runs every clock; pending flags drop when their voice is serviced.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_gate_d   <= '0;
            r_hist_vld <= 1'b0;
            r_pend_on  <= '0;
            r_pend_off <= '0;
        end else begin
            r_gate_d   <= gate;
            r_hist_vld <= 1'b1;
            r_pend_on  <= (r_pend_on & ~w_svc) | w_rise;
            r_pend_off <= (r_pend_off & ~w_svc) | w_fall;
        end
    end

    // Release step: linear by the full rate, or exponential with a +1 floor.
`ifdef ENV_EXP_RELEASE_EN
    logic w_unused_rel;
    assign w_unused_rel = ^release_rate[15:4];
    assign w_rdec       = {1'b0, w_cur_lv >> release_rate[3:0]} + 17'd1;
    assign w_rel_hold   = 1'b0;
`else
    assign w_rdec     = {1'b0, release_rate};
    assign w_rel_hold = (release_rate == 16'd0);
`endif

    // Next state and level for the voice being serviced this cycle.
    always_comb begin
        w_cur_st = r_state[r_idx];
        w_cur_lv = r_level[r_idx];
        w_eff_st = w_cur_st;
        if (r_pend_on[r_idx]) begin
            w_eff_st = S_ATTACK;
        end else if (r_pend_off[r_idx] ||
                     (!gate[r_idx] &&
                      (w_cur_st == S_ATTACK ||
                       w_cur_st == S_DECAY ||
                       w_cur_st == S_SUSTAIN))) begin
            w_eff_st = S_RELEASE;
        end
        w_add    = {1'b0, w_cur_lv} + {1'b0, attack_rate};
        w_dsub   = {1'b0, w_cur_lv} - {1'b0, decay_rate};
        w_rsub   = {1'b0, w_cur_lv} - w_rdec;
        w_nxt_st = w_eff_st;
        w_nxt_lv = w_cur_lv;
        unique case (w_eff_st)
            S_IDLE: begin
                w_nxt_lv = '0;
            end
            S_ATTACK: begin
                if (w_add[16] || (w_add[15:0] == 16'hFFFF)) begin
                    w_nxt_lv = 16'hFFFF;
                    w_nxt_st = S_DECAY;
                end else begin
                    w_nxt_lv = w_add[15:0];
                end
            end
            S_DECAY: begin
                if (decay_rate != 16'd0) begin
                    if (w_dsub[16] || (w_dsub[15:0] <= sustain_level)) begin
                        w_nxt_lv = sustain_level;
                        w_nxt_st = S_SUSTAIN;
                    end else begin
                        w_nxt_lv = w_dsub[15:0];
                    end
                end
            end
            S_SUSTAIN: begin
                w_nxt_lv = sustain_level;
            end
            S_RELEASE: begin
                if (!w_rel_hold) begin
                    if (w_rsub[16] || (w_rsub[15:0] == 16'd0)) begin
                        w_nxt_lv = '0;
                        w_nxt_st = S_IDLE;
                    end else begin
                        w_nxt_lv = w_rsub[15:0];
                    end
                end
            end
            default: begin
                w_nxt_lv = '0;
                w_nxt_st = S_IDLE;
            end
        endcase
    end

    // Per-voice state register: only the serviced voice is written.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                r_state[i] <= S_IDLE;
                r_level[i] <= '0;
            end
        end else if (r_busy) begin
            r_state[r_idx] <= w_nxt_st;
            r_level[r_idx] <= w_nxt_lv;
        end
    end

endmodule
